// File: rtl/mul_seq_pkg.sv
// Shared ALU definitions: default datapath width, multiplier FSM states and
// the MUL opcode that the ALU decoder uses to steer start.
package mul_seq_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  localparam logic [3:0] ALU_OP_MUL = 4'd6;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencing for the shift-add multiplier: FSM, iteration counter,
// registered busy/done and load/step/finish strobes to the datapath.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic finish
);

  mul_state_t       state;
  logic [CNT_W-1:0] count;

  // A new request is accepted from IDLE and also from DONE (back-to-back).
  assign load   = start && (state == ST_IDLE || state == ST_DONE);
  assign step   = (state == ST_RUN);
  assign finish = step && (count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            count <= CNT_W'(WIDTH);
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            count <= CNT_W'(WIDTH);
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle unsigned shift-add multiplier: one WIDTH+1-bit partial add per
// cycle, product and overflow flag held stable until the next completion.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             load, step, finish;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_hi_n, acc_lo_n;

  mul_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .load   (load),
    .step   (step),
    .finish (finish)
  );

  // Carry out of the partial add becomes the top bit of acc_hi after the shift.
  always_comb begin
    sum = {1'b0, acc_hi};
    if (acc_lo[0]) sum = {1'b0, acc_hi} + {1'b0, mcand};
    {acc_hi_n, acc_lo_n} = {sum, acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      product_lo <= '0;
      product_hi <= '0;
      ovf        <= 1'b0;
    end else begin
      if (load) begin
        mcand  <= a;
        acc_hi <= '0;
        acc_lo <= b;
      end else if (step) begin
        acc_hi <= acc_hi_n;
        acc_lo <= acc_lo_n;
      end
      // Capture the final iteration's result on the edge that enters DONE.
      if (finish) begin
        product_hi <= acc_hi_n;
        product_lo <= acc_lo_n;
        ovf        <= (acc_hi_n != '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq against a plain 64-bit multiply model.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, ovf;
  logic [31:0] product_lo, product_hi;

  int checks = 0;
  int failures = 0;

  mul_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Issue a one-cycle start and wait (bounded) for done; n counts edges from
  // the accepting edge up to and including the one that raises done.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output int n, output int bcnt);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    bcnt = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ovf} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: busy/done/ovf=%b required 000", {busy, done, ovf});
    end
    checks++;
    if ({product_hi, product_lo} !== 64'd0) begin
      failures++;
      $display("FAIL reset_product: got %h required 0", {product_hi, product_lo});
    end
    rst = 1'b0;
  endtask

  task automatic test_op(input string name, input logic [31:0] ia, input logic [31:0] ib);
    int n, bcnt;
    logic [63:0] exp;
    exp = 64'(ia) * 64'(ib);
    run_op(ia, ib, n, bcnt);
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL %s_latency: done after %0d cycles required 33", name, n);
    end
    checks++;
    if (bcnt !== 32) begin
      failures++;
      $display("FAIL %s_busy: busy for %0d cycles required 32", name, bcnt);
    end
    checks++;
    if ({product_hi, product_lo} !== exp) begin
      failures++;
      $display("FAIL %s_product: a=%h b=%h got %h required %h", name, ia, ib,
               {product_hi, product_lo}, exp);
    end
    checks++;
    if (ovf !== (exp[63:32] != 0)) begin
      failures++;
      $display("FAIL %s_ovf: got %b required %b", name, ovf, exp[63:32] != 0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: done=%b one cycle later required 0", name, done);
    end
  endtask

  task automatic test_basic();
    test_op("basic", 32'd3, 32'd5);
  endtask

  task automatic test_carry();
    test_op("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_zero_boundary();
    test_op("zero", 32'd0, 32'h1234_5678);
    test_op("bzero", 32'hDEAD_BEEF, 32'd0);
    test_op("msb", 32'h8000_0000, 32'd2);
  endtask

  task automatic test_ignored_start();
    int n;
    int extra = 0;
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0; a = 32'd0; b = 32'd0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 10) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL ignored_latency: done after %0d cycles required 33", n);
    end
    checks++;
    if ({product_hi, product_lo} !== 64'd42) begin
      failures++;
      $display("FAIL ignored_product: got %0d required 42", {product_hi, product_lo});
    end
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL ignored_no_second_done: saw %0d done pulses required 0", extra);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    int extra = 0;
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 1; i < 12; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, ovf} !== 3'b000 || {product_hi, product_lo} !== 64'd0) begin
      failures++;
      $display("FAIL midreset_clear: busy/done/ovf=%b product=%h required 000 and 0",
               {busy, done, ovf}, {product_hi, product_lo});
    end
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL midreset_aborted: %0d cycles with busy/done required 0", extra);
    end
    run_op(32'd100, 32'd100, n, extra);
    checks++;
    if (n !== 33 || {product_hi, product_lo} !== 64'd10000) begin
      failures++;
      $display("FAIL midreset_fresh: latency %0d product %0d required 33 and 10000",
               n, {product_hi, product_lo});
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int drift = 0;
    @(negedge clk);
    start = 1'b1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({product_hi, product_lo} !== 64'd6) begin
      failures++;
      $display("FAIL b2b_first: got %0d required 6", {product_hi, product_lo});
    end
    // Still in the DONE cycle: the held start takes the new operands.
    a = 32'd4; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if ({product_hi, product_lo} !== 64'd6) drift++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (drift !== 0) begin
      failures++;
      $display("FAIL b2b_hold: product moved in %0d cycles required 0", drift);
    end
    checks++;
    if (n !== 33) begin
      failures++;
      $display("FAIL b2b_latency: second done after %0d cycles required 33", n);
    end
    checks++;
    if ({product_hi, product_lo} !== 64'd20) begin
      failures++;
      $display("FAIL b2b_second: got %0d required 20", {product_hi, product_lo});
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 8; i++) begin
      test_op("random", 32'($urandom), 32'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero_boundary();
    test_ignored_start();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle unsigned shift-add multiplier for the ALU datapath.
- Sits downstream of the 32-bit adder: consumes one partial-sum addition per cycle and accumulates the 2*WIDTH-bit product.
- Gives the ALU its MUL result without a combinational array multiplier.
- Start/busy/done handshake toward the ALU control; product held stable until the next start.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; a/b sampled on the cycle start=1 is accepted.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when the product is valid.
- product_lo  output  WIDTH  low half of a*b.
- product_hi  output  WIDTH  high half of a*b.
- ovf  output  1  product_hi != 0, i.e. the product does not fit in WIDTH bits.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE.
  - busy=0, done=0, ovf=0.
  - product_lo=0, product_hi=0, counter=0.
  - Reset during RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mcand<=a.
  - Initialises acc_hi<=0, acc_lo<=b, counter<=WIDTH.
  - Moves to RUN; busy=1 from the next cycle.
- RUN, one iteration per cycle:
  - If acc_lo[0]=1: sum = {1'b0,acc_hi} + {1'b0,mcand} (WIDTH+1 bits, carry kept). Otherwise sum = {1'b0,acc_hi}.
  - Shift right: {acc_hi,acc_lo} <= {sum, acc_lo[WIDTH-1:1]}.
  - counter decrements.
  - When counter reaches 1 and that iteration completes, go to DONE.
  - start is ignored in RUN; a and b may change freely.
- DONE (one cycle):
  - done=1, busy=0.
  - product_hi/product_lo are registered from acc; ovf=(acc_hi!=0).
  - Next state is IDLE, unless start=1 in this cycle, in which case the new request is accepted exactly as in IDLE and the next state is RUN (back-to-back).
- Latency:
  - start accepted at edge N, busy=1 for cycles N+1..N+WIDTH, done=1 at cycle N+WIDTH+1.
  - That is WIDTH+1 cycles from start to done.
- Output stability: product_hi, product_lo and ovf change only on the DONE-entry update and on reset. They hold through IDLE and through a following RUN.
- Arithmetic:
  - Unsigned only.
  - Carry-out of each partial add must never be dropped (WIDTH+1-bit sum).
  - Result is exact for all operand pairs.
- Boundary cases:
  - a=0 or b=0 still takes the full WIDTH iterations (no early exit); product=0, ovf=0.
  - start held high continuously gives back-to-back operations with a one-cycle DONE between them.
  - start and rst asserted together: rst wins.

Decomposition:
- Shared ALU package holds:
  - WIDTH default (32).
  - FSM state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - ALU opcode constant for MUL, used by the ALU decoder to steer start.
- One natural sub-module: mul_seq_ctrl, containing the FSM, counter and busy/done generation.
  - Outputs load/step/finish strobes to the datapath.
  - The WIDTH+1-bit adder and shift register stay in mul_seq.

Test Plan:
- Basic: rst for 2 cycles, then start with a=3, b=5 -> busy for 32 cycles; done pulse 33 cycles after start; product_lo=15, product_hi=0, ovf=0.
- Carry check: a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product_hi=32'hFFFFFFFE, product_lo=32'h00000001, ovf=1.
- Zero/boundary: a=0, b=32'h12345678 -> product 0, ovf=0, done still at +33 cycles. Then a=32'h80000000, b=2 -> product_hi=1, product_lo=0, ovf=1.
- Ignored start: start a=7, b=6; pulse start with a=9, b=9 at cycle +10 -> done at +33 with product_lo=42; no second done follows.
- Reset mid-op: start a=100, b=100; rst=1 at cycle +12 -> busy=0, done=0, product=0 from the next cycle. No done ever appears for that operation; a fresh start then works (product_lo=10000).
- Back-to-back: start held high with a=2, b=3 then a=4, b=5 presented on the DONE cycle -> first done shows 6; second done exactly 33 cycles later shows 20. Outputs hold 6 in between.
